// File: rtl/control_montacargas.sv
// Freight elevator controller for five floors with collective service and latched calls.
// Optional emergency stop input paro is enabled by defining PARADA_EMERGENCIA_EN.
module control_montacargas #(
  parameter int TIEMPO_VIAJE  = 8,
  parameter int TIEMPO_PUERTA = 16
) (
  input  logic       clk,
  input  logic       reset,
`ifdef PARADA_EMERGENCIA_EN
  input  logic       paro,
`endif
  input  logic [4:0] llamada,
  output logic [3:0] estado,
  output logic [4:0] pendientes,
  output logic       puerta_abierta,
  output logic       sentido
);

  typedef enum logic [3:0] {
    piso1  = 4'd0,  piso2  = 4'd1,  piso3  = 4'd2,  piso4  = 4'd3,  piso5 = 4'd4,
    subir2 = 4'd5,  subir3 = 4'd6,  subir4 = 4'd7,  subir5 = 4'd8,
    bajar1 = 4'd9,  bajar2 = 4'd10, bajar3 = 4'd11, bajar4 = 4'd12
  } estado_t;

  localparam int WV = $clog2(TIEMPO_VIAJE + 1);
  localparam int WP = $clog2(TIEMPO_PUERTA + 1);

  estado_t       est, est_d;
  logic [WV-1:0] cnt_viaje, cnt_viaje_d;
  logic [WP-1:0] cnt_puerta, cnt_puerta_d;
  logic [4:0]    pend_d, limpiar;
  logic          puerta_d, sentido_d;
  logic [2:0]    piso_idx;
  logic          arriba, abajo;
  logic          congelar;

`ifdef PARADA_EMERGENCIA_EN
  assign congelar = paro;
`else
  assign congelar = 1'b0;
`endif

  assign estado = est;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      est            <= piso1;
      cnt_viaje      <= '0;
      cnt_puerta     <= '0;
      pendientes     <= '0;
      puerta_abierta <= 1'b0;
      sentido        <= 1'b1;
    end else begin
      est            <= est_d;
      cnt_viaje      <= cnt_viaje_d;
      cnt_puerta     <= cnt_puerta_d;
      pendientes     <= pend_d;
      puerta_abierta <= puerta_d;
      sentido        <= sentido_d;
    end
  end

  // Floor states encode the floor index directly, so travel targets are fixed offsets.
  always_comb begin
    est_d        = est;
    cnt_viaje_d  = cnt_viaje;
    cnt_puerta_d = cnt_puerta;
    puerta_d     = puerta_abierta;
    sentido_d    = sentido;
    limpiar      = '0;
    piso_idx     = est[2:0];
    arriba       = 1'b0;
    abajo        = 1'b0;

    for (int i = 0; i < 5; i++) begin
      if (pendientes[i] && (i > int'(piso_idx))) arriba = 1'b1;
      if (pendientes[i] && (i < int'(piso_idx))) abajo  = 1'b1;
    end

    // While the door is open the served floor keeps ignoring its call button.
    if (puerta_abierta) limpiar[piso_idx] = 1'b1;

    if (!congelar) begin
      if (est <= piso5) begin
        if (puerta_abierta) begin
          if (cnt_puerta == WP'(TIEMPO_PUERTA - 1)) begin
            puerta_d     = 1'b0;
            cnt_puerta_d = '0;
          end else begin
            cnt_puerta_d = cnt_puerta + 1'b1;
          end
        end else if (pendientes[piso_idx]) begin
          puerta_d          = 1'b1;
          cnt_puerta_d      = '0;
          limpiar[piso_idx] = 1'b1;
        end else if (arriba && sentido) begin
          est_d       = estado_t'(est + 4'd5);
          cnt_viaje_d = '0;
        end else if (abajo) begin
          est_d       = estado_t'(est + 4'd8);
          cnt_viaje_d = '0;
          sentido_d   = 1'b0;
        end else if (arriba) begin
          est_d       = estado_t'(est + 4'd5);
          cnt_viaje_d = '0;
          sentido_d   = 1'b1;
        end
        if (est == piso1)      sentido_d = 1'b1;
        else if (est == piso5) sentido_d = 1'b0;
      end else if (est <= subir5) begin
        if (cnt_viaje == WV'(TIEMPO_VIAJE - 1)) begin
          est_d       = estado_t'(est - 4'd4);
          cnt_viaje_d = '0;
        end else begin
          cnt_viaje_d = cnt_viaje + 1'b1;
        end
      end else if (est <= bajar4) begin
        if (cnt_viaje == WV'(TIEMPO_VIAJE - 1)) begin
          est_d       = estado_t'(est - 4'd9);
          cnt_viaje_d = '0;
        end else begin
          cnt_viaje_d = cnt_viaje + 1'b1;
        end
      end else begin
        est_d        = piso1;
        puerta_d     = 1'b0;
        cnt_viaje_d  = '0;
        cnt_puerta_d = '0;
      end
    end

    pend_d = (pendientes | llamada) & ~limpiar;
  end

endmodule

// File: doc/control_montacargas.md
CONTROL_MONTACARGAS -- requirements
Module: control_montacargas

Interface
REQ-001 Parameter TIEMPO_VIAJE, default 8: cycles spent in each travel state (minimum 1).
REQ-002 Parameter TIEMPO_PUERTA, default 16: cycles the door stays open at a served floor (minimum 1).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 llamada  input  5  call buttons, bit n-1 = floor n; any high sample latches a request.
REQ-006 estado  output  4  registered elevator state in the team motor-state encoding: piso1..piso5 = 0..4, subir2..subir5 = 5..8, bajar1..bajar4 = 9..12.
REQ-007 pendientes  output  5  registered latched-request vector.
REQ-008 puerta_abierta  output  1  registered door-open indication.
REQ-009 sentido  output  1  registered direction preference: 1 = up, 0 = down.

Function
REQ-010 Request latching SHALL use pendientes <= pendientes | llamada every cycle, so a call at cycle t is visible at t+1; clears (REQ-013) take priority for the same bit.
REQ-011 A travel state subir(n)/bajar(n) SHALL last exactly TIEMPO_VIAJE cycles, then enter piso(n); a travel state is never aborted or reversed.
REQ-012 Arrival cycle A at piso(n) with pendientes[n-1]=1 SHALL be a stop.
REQ-013 At a stop: pendientes[n-1] = 0 and puerta_abierta = 1 for cycles A+1..A+TIEMPO_PUERTA; llamada[n-1] is ignored during this window; estado holds piso(n).
REQ-014 A piso(n) cycle with the door closed SHALL be a decision cycle, using the registered pendientes: arrival with no stop, cycle A+TIEMPO_PUERTA+1 after a stop, or idle.
REQ-015 Decision when pendientes[n-1]=1 (idle call at the current floor): start a stop, so puerta_abierta rises the next cycle.
REQ-016 Decision otherwise: if any request is above and sentido=1, enter subir(n+1); else if any request is below, enter bajar(n-1) and set sentido=0; else if any request is above, enter subir(n+1) and set sentido=1; else remain in piso(n) (idle).
REQ-017 Symmetric rule when sentido=0: prefer requests below, then requests above.
REQ-018 Boundaries: sentido forced to 0 at piso5 and to 1 at piso1; floors passed en route are visited one cycle each (collective service).
REQ-019 Codes 13-15 in estado SHALL transition to piso1 on the next edge, with puerta_abierta=0.
REQ-020 Simultaneous calls on several floors SHALL all latch in the same cycle; none are lost.

Reset
REQ-021 Reset asserted SHALL immediately force estado=piso1, pendientes=0, puerta_abierta=0, sentido=1, and all counters to 0, including mid-travel or mid-stop.
REQ-022 After reset deassertion, the first edge SHALL perform a normal piso1 decision cycle.

Configuration
REQ-023 Macro PARADA_EMERGENCIA_EN SHALL add input paro (1 bit, active-high).
REQ-024 With PARADA_EMERGENCIA_EN defined: while paro=1, estado, the travel and door counters, and puerta_abierta freeze; request latching continues; operation resumes where it left off when paro=0.
REQ-025 Without PARADA_EMERGENCIA_EN, the paro port and its logic SHALL be absent.

Verification (TIEMPO_VIAJE=4, TIEMPO_PUERTA=3)
REQ-026 Idle at piso1, llamada=00100 pulsed at cycle 0 -> pendientes=00100 at cycle 1; subir2 cycles 2-5; piso2 cycle 6; subir3 cycles 7-10; piso3 cycle 11; puerta_abierta=1 and pendientes=0 cycles 12-14; idle at piso3 from cycle 15.
REQ-027 Idle at piso3, sentido=1, llamada=10001 at once -> travel to piso5 first, stop, sentido=0, then bajar4..bajar1 to piso1, stop; pendientes=0 at end.
REQ-028 Idle at piso2, llamada=00010 -> puerta_abierta=1 from the second cycle after the call, for 3 cycles, with no travel state.
REQ-029 Reset asserted during subir4 -> estado=0, pendientes=0, puerta_abierta=0 asynchronously, before the next clock edge.
REQ-030 With PARADA_EMERGENCIA_EN, paro=1 for 5 cycles during bajar2 -> bajar2 lasts 9 cycles in total; a call latched during paro is served afterwards.
